// File: rtl/line_responder_if.sv
// line_responder_if: requester strobe/response and backend word-bus signals of line_responder.
interface line_responder_if #(parameter int ADDR_W = 27);
    logic              req_enable;
    logic              req_read;
    logic [ADDR_W-1:0] req_addr;
    logic [127:0]      req_wdata;
    logic              resp_available;
    logic [127:0]      resp_data;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              busy;
    logic              err_overflow;
    modport slave (
        input  req_enable, req_read, req_addr, req_wdata, mem_ack, mem_rdata,
        output resp_available, resp_data, mem_req, mem_we, mem_addr, mem_wdata, busy, err_overflow
    );
    modport master (
        output req_enable, req_read, req_addr, req_wdata, mem_ack, mem_rdata,
        input  resp_available, resp_data, mem_req, mem_we, mem_addr, mem_wdata, busy, err_overflow
    );
endinterface

// File: rtl/line_responder.sv
// line_responder: queues 128-bit line reads/writes in a 2-entry FIFO and runs each as four 32-bit backend beats.
module line_responder #(parameter int ADDR_W = 27) (
    input logic              clk,
    input logic              rstn,
    line_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;
    state_t                  r_state, w_next;
    logic [1:0]              r_rd;
    logic [1:0][ADDR_W-5:0]  r_line;
    logic [1:0][127:0]       r_wd;
    logic                    r_wp, r_rp;
    logic [1:0]              r_cnt;
    logic [1:0]              r_beat;
    logic [95:0]             r_rbuf;
    logic [127:0]            r_resp;
    logic                    r_ovf;
    logic                    w_beat_on, w_cur_rd, w_last, w_pop, w_push, w_more;
    assign w_beat_on = r_state == BEAT;
    assign w_cur_rd  = r_rd[r_rp];
    assign w_last    = w_beat_on && bus.mem_ack && r_beat == 2'd3;
    assign w_pop     = w_last;
    // the head entry stays queued until its last beat, so a pop that cycle frees a slot
    assign w_push    = bus.req_enable && (r_cnt != 2'd2 || w_pop);
    assign w_more    = ({1'b0, w_pop} < r_cnt) || w_push;
    always_comb begin
        w_next = (w_beat_on && !w_last) ? BEAT : (w_beat_on && w_cur_rd) ? RESP : w_more ? BEAT : IDLE;
    end
    assign bus.mem_req        = w_beat_on;
    assign bus.mem_we         = w_beat_on && !w_cur_rd;
    assign bus.mem_addr       = w_beat_on ? {r_line[r_rp], r_beat, 2'b00} : '0;
    assign bus.mem_wdata      = bus.mem_we ? r_wd[r_rp][{r_beat, 5'd0} +: 32] : '0;
    assign bus.resp_available = r_state == RESP;
    assign bus.resp_data      = r_resp;
    assign bus.busy           = r_cnt != 2'd0 || r_state != IDLE;
    assign bus.err_overflow   = r_ovf;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_rd    <= '0;
            r_line  <= '0;
            r_wd    <= '0;
            r_wp    <= 1'b0;
            r_rp    <= 1'b0;
            r_cnt   <= '0;
            r_beat  <= '0;
            r_rbuf  <= '0;
            r_resp  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_push) begin
                r_rd[r_wp]   <= bus.req_read;
                r_line[r_wp] <= bus.req_addr[ADDR_W-1:4];
                r_wd[r_wp]   <= bus.req_wdata;
                r_wp         <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
            if (bus.req_enable && !w_push) r_ovf <= 1'b1;
            if (w_beat_on && bus.mem_ack) begin
                r_beat <= r_beat + 2'd1;
                if (w_cur_rd && w_last) r_resp <= {bus.mem_rdata, r_rbuf};
                else if (w_cur_rd) r_rbuf[{r_beat, 5'd0} +: 32] <= bus.mem_rdata;
            end
        end
    end
endmodule
